// File: rtl/imm_decode_stage.sv
// Pipelined, self-decoding immediate generator with a 2-entry skid buffer.
// Optional build macro IMM_RVC_EN enables decoding of compressed (RVC) words.
module imm_decode_stage #(
  parameter int XLEN      = 32,
  parameter bit TARGET_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_J   = 3'd4;
  localparam logic [2:0] T_U   = 3'd5;
  localparam logic [2:0] T_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [2:0]      typ;
    logic            illegal;
  } entry_t;

  // Widen a 32-bit two's-complement immediate to XLEN (replication count >= 1 for XLEN 32/64).
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  logic [6:0]  opcode_s;
  logic [31:0] raw_s;
  logic [2:0]  dec_type_s;
  entry_t      dec_s;
  entry_t      main_r;
  entry_t      skid_r;
  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        accept_s;
  logic        drain_s;
  logic        load_main_s;
  logic        load_skid_s;
  logic        main_from_skid_s;

  assign opcode_s = in_instr[6:0];

  // Opcode-driven format selection and 32-bit raw immediate assembly.
  always_comb begin
    dec_type_s = T_ILL;
    raw_s      = 32'd0;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode_s)
        7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          dec_type_s = T_I;
          raw_s      = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        7'b0100011: begin
          dec_type_s = T_S;
          raw_s      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        7'b1100011: begin
          dec_type_s = T_B;
          raw_s      = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
        end
        7'b1101111: begin
          dec_type_s = T_J;
          raw_s      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_type_s = T_U;
          raw_s      = {in_instr[31:12], 12'b0};
        end
        7'b0110011: begin
          dec_type_s = T_R;
          raw_s      = 32'd0;
        end
        default: begin
          if ((XLEN == 32'd64) && (opcode_s == 7'b0011011)) begin
            dec_type_s = T_I;
            raw_s      = {{20{in_instr[31]}}, in_instr[31:20]};
          end else if ((XLEN == 32'd64) && (opcode_s == 7'b0111011)) begin
            dec_type_s = T_R;
            raw_s      = 32'd0;
          end else begin
            dec_type_s = T_ILL;
            raw_s      = 32'd0;
          end
        end
      endcase
    end else begin
`ifdef IMM_RVC_EN
      // Compressed word: only the low half participates.
      case ({in_instr[1:0], in_instr[15:13]})
        5'b01_000, 5'b01_010: begin
          dec_type_s = T_I;
          raw_s      = {{26{in_instr[12]}}, in_instr[12], in_instr[6:2]};
        end
        5'b01_101: begin
          dec_type_s = T_J;
          raw_s      = {{20{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9],
                        in_instr[6], in_instr[7], in_instr[2], in_instr[11], in_instr[5:3], 1'b0};
        end
        5'b01_110, 5'b01_111: begin
          dec_type_s = T_B;
          raw_s      = {{23{in_instr[12]}}, in_instr[12], in_instr[6:5], in_instr[2],
                        in_instr[11:10], in_instr[4:3], 1'b0};
        end
        5'b00_010: begin
          dec_type_s = T_I;
          raw_s      = {25'd0, in_instr[5], in_instr[12:10], in_instr[6], 2'b00};
        end
        5'b00_110: begin
          dec_type_s = T_S;
          raw_s      = {25'd0, in_instr[5], in_instr[12:10], in_instr[6], 2'b00};
        end
        default: begin
          dec_type_s = T_ILL;
          raw_s      = 32'd0;
        end
      endcase
`else
      dec_type_s = T_ILL;
      raw_s      = 32'd0;
`endif
    end
  end

  // Package the decoded entry, including the precomputed pc-relative target.
  always_comb begin
    dec_s.typ     = dec_type_s;
    dec_s.illegal = (dec_type_s == T_ILL);
    dec_s.imm     = sext32(raw_s);
    dec_s.pc      = in_pc;
    if (TARGET_EN) begin
      dec_s.target = in_pc + dec_s.imm;
    end else begin
      dec_s.target = {XLEN{1'b0}};
    end
  end

  assign accept_s = in_valid & in_ready_r;
  assign drain_s  = out_valid_r & out_ready;

  // Skid-buffer occupancy FSM and slot load selects.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_ONE;
          load_main_s = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && drain_s) begin
          state_nxt_s = ST_ONE;
          load_main_s = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = ST_TWO;
          load_skid_s = 1'b1;
        end else if (drain_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (drain_s) begin
          state_nxt_s      = ST_ONE;
          main_from_skid_s = 1'b1;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // State, handshake flags and slot storage; handshake flags derive from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_r      <= '0;
      skid_r      <= '0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      if (load_main_s) begin
        main_r <= dec_s;
      end else if (main_from_skid_s) begin
        main_r <= skid_r;
      end
      if (load_skid_s) begin
        skid_r <= dec_s;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_imm     = main_r.imm;
  assign out_type    = main_r.typ;
  assign out_pc      = main_r.pc;
  assign out_target  = main_r.target;
  assign out_illegal = main_r.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: vector table through a scoreboard,
// stall/ordering and reset-while-full sequences, plus an XLEN=64 instance.
module tb_imm_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  typ;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  typ;
    logic [63:0] imm;
  } vec64_t;

`ifdef IMM_RVC_EN
  localparam logic [2:0]  RVC_LI_T = 3'd1;
  localparam logic [31:0] RVC_LI_I = 32'hFFFF_FFFF;
  localparam logic [2:0]  RVC_LW_T = 3'd1;
  localparam logic [31:0] RVC_LW_I = 32'h0000_004C;
`else
  localparam logic [2:0]  RVC_LI_T = 3'd7;
  localparam logic [31:0] RVC_LI_I = 32'h0;
  localparam logic [2:0]  RVC_LW_T = 3'd7;
  localparam logic [31:0] RVC_LW_I = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_type;
  logic [31:0] out_pc;
  logic [31:0] out_target;
  logic        out_illegal;

  logic        rand_rdy;
  logic        man_rdy;
  logic        rnd_bit;

  logic        i64_valid;
  logic        i64_ready;
  logic [31:0] i64_instr;
  logic [63:0] i64_pc;
  logic        o64_valid;
  logic [63:0] o64_imm;
  logic [2:0]  o64_type;
  logic [63:0] o64_pc;
  logic [63:0] o64_target;
  logic        o64_illegal;

  int   errors = 0;
  int   checks = 0;
  exp_t drv_exp;
  exp_t sb_q[$];
  vec_t vecs[14];
  vec64_t v64[5];

  assign out_ready = rand_rdy ? rnd_bit : man_rdy;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TARGET_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_type(out_type),
    .out_pc(out_pc), .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_decode_stage #(.XLEN(64), .TARGET_EN(1'b1)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(i64_valid), .in_ready(i64_ready), .in_instr(i64_instr), .in_pc(i64_pc),
    .out_valid(o64_valid), .out_ready(1'b1), .out_imm(o64_imm), .out_type(o64_type),
    .out_pc(o64_pc), .out_target(o64_target), .out_illegal(o64_illegal)
  );

  task automatic chk(input logic ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] typ,
                       input logic [31:0] imm);
    in_instr       = instr;
    in_pc          = pc;
    in_valid       = 1'b1;
    drv_exp.imm    = imm;
    drv_exp.pc     = pc;
    drv_exp.target = pc + imm;
    drv_exp.typ    = typ;
    drv_exp.ill    = (typ == 3'd7);
  endtask

  // Holds the current offer until the handshake edge, then returns just after it.
  task automatic wait_accept();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk(got, "accept_timeout", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] typ,
                      input logic [31:0] imm);
    drive(instr, pc, typ, imm);
    wait_accept();
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk(done, "drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard: every visible entry must match the queue head; pop on handshake.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
      end else begin
        if (out_valid) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: out_valid=1 type=%0d imm=%h, required no entry", out_type, out_imm);
          end else begin
            e = sb_q[0];
            if (out_type !== e.typ || out_imm !== e.imm || out_pc !== e.pc ||
                out_target !== e.target || out_illegal !== e.ill) begin
              errors++;
              $display("FAIL out_entry: got type=%0d imm=%h pc=%h tgt=%h ill=%b, required type=%0d imm=%h pc=%h tgt=%h ill=%b",
                       out_type, out_imm, out_pc, out_target, out_illegal,
                       e.typ, e.imm, e.pc, e.target, e.ill);
            end
            if (out_ready) void'(sb_q.pop_front());
          end
        end
        if (in_valid && in_ready) sb_q.push_back(drv_exp);
      end
    end
  endtask

  task automatic rnd_gen();
    forever begin
      @(posedge clk); #1;
      rnd_bit = ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    vecs[0]  = '{32'hFFF0_0093, 32'h0000_0000, 3'd1, 32'hFFFF_FFFF};
    vecs[1]  = '{32'h0080_006F, 32'h0000_1000, 3'd4, 32'h0000_0008};
    vecs[2]  = '{32'hFE00_0EE3, 32'h0000_0100, 3'd3, 32'hFFFF_FFFC};
    vecs[3]  = '{32'h1234_50B7, 32'h0000_0010, 3'd5, 32'h1234_5000};
    vecs[4]  = '{32'h0000_007F, 32'h0000_0200, 3'd7, 32'h0000_0000};
    vecs[5]  = '{32'hFE20_AC23, 32'h0000_0300, 3'd2, 32'hFFFF_FFF8};
    vecs[6]  = '{32'h0020_81B3, 32'h0000_0040, 3'd0, 32'h0000_0000};
    vecs[7]  = '{32'h0000_50FD, 32'h0000_0044, RVC_LI_T, RVC_LI_I};
    vecs[8]  = '{32'h0000_1097, 32'h0000_2000, 3'd5, 32'h0000_1000};
    vecs[9]  = '{32'hFFDF_F06F, 32'h0000_0000, 3'd4, 32'hFFFF_FFFC};
    vecs[10] = '{32'h41F0_D093, 32'h0000_0500, 3'd1, 32'h0000_041F};
    vecs[11] = '{32'h0000_0012, 32'h0000_0600, 3'd7, 32'h0000_0000};
    vecs[12] = '{32'h0000_001B, 32'h0000_0700, 3'd7, 32'h0000_0000};
    vecs[13] = '{32'h0000_4460, 32'h0000_0800, RVC_LW_T, RVC_LW_I};

    v64[0] = '{32'h1234_50B7, 64'h0, 3'd5, 64'h0000_0000_1234_5000};
    v64[1] = '{32'h8000_00B7, 64'h0, 3'd5, 64'hFFFF_FFFF_8000_0000};
    v64[2] = '{32'hFFF0_009B, 64'h8, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    v64[3] = '{32'h0020_80BB, 64'h10, 3'd0, 64'h0};
    v64[4] = '{32'hFE00_0EE3, 64'h100, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC};

    reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    rand_rdy = 1'b0; man_rdy = 1'b1; rnd_bit = 1'b0;
    i64_valid = 1'b0; i64_instr = 32'h0; i64_pc = 64'h0;
    drv_exp = '{32'h0, 32'h0, 32'h0, 3'd0, 1'b0};
    fork
      monitor();
      rnd_gen();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk(in_ready == 1'b1, "rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk({out_imm, out_pc, out_target, out_type, out_illegal} == 100'd0, "rst_outputs",
        {28'd0, out_imm, out_type, out_illegal}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency: visible right after the accepting edge, gone one edge later.
    drive(32'hFFF0_0093, 32'h0, 3'd1, 32'hFFFF_FFFF);
    chk(out_valid == 1'b0, "lat_before", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(out_valid == 1'b1, "lat_valid", {63'd0, out_valid}, 64'd1);
    chk(out_type == 3'd1 && out_imm == 32'hFFFF_FFFF, "lat_data", {29'd0, out_type, out_imm},
        {29'd0, 3'd1, 32'hFFFF_FFFF});
    @(posedge clk); #1;
    chk(out_valid == 1'b0, "lat_one_cycle", {63'd0, out_valid}, 64'd0);

    // Vector table under random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 14; i++) send(vecs[i].instr, vecs[i].pc, vecs[i].typ, vecs[i].imm);
    in_valid = 1'b0;
    rand_rdy = 1'b0; man_rdy = 1'b1;
    wait_drain();

    // Stall: two accepted, third held, then in-order release.
    man_rdy = 1'b0;
    send(32'h0080_006F, 32'h0000_1000, 3'd4, 32'h0000_0008);
    send(32'hFE00_0EE3, 32'h0000_0100, 3'd3, 32'hFFFF_FFFC);
    drive(32'h1234_50B7, 32'h0000_0020, 3'd5, 32'h1234_5000);
    for (int k = 0; k < 3; k++) begin
      chk(in_ready == 1'b0, "stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk(out_valid == 1'b1, "stall_out_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
    end
    man_rdy = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    wait_drain();

    // Reset while both slots are full discards everything.
    man_rdy = 1'b0;
    send(32'h0000_007F, 32'h0000_0400, 3'd7, 32'h0);
    send(32'hFFF0_0093, 32'h0000_0404, 3'd1, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    chk(in_ready == 1'b0, "two_in_ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk(out_valid == 1'b0, "rst2_out_valid", {63'd0, out_valid}, 64'd0);
    chk(in_ready == 1'b1, "rst2_in_ready", {63'd0, in_ready}, 64'd1);
    chk({out_imm, out_pc, out_target, out_type, out_illegal} == 100'd0, "rst2_outputs",
        {28'd0, out_imm, out_type, out_illegal}, 64'd0);
    reset = 1'b0;
    man_rdy = 1'b1;
    @(posedge clk); #1;
    chk(out_valid == 1'b0, "rst2_discard", {63'd0, out_valid}, 64'd0);

    // XLEN=64 instance, always ready downstream.
    for (int i = 0; i < 5; i++) begin
      i64_instr = v64[i].instr;
      i64_pc    = v64[i].pc;
      i64_valid = 1'b1;
      @(posedge clk); #1;
      chk(o64_valid == 1'b1, "x64_valid", {63'd0, o64_valid}, 64'd1);
      chk(o64_type == v64[i].typ, "x64_type", {61'd0, o64_type}, {61'd0, v64[i].typ});
      chk(o64_imm == v64[i].imm, "x64_imm", o64_imm, v64[i].imm);
      chk(o64_target == v64[i].pc + v64[i].imm, "x64_target", o64_target, v64[i].pc + v64[i].imm);
    end
    i64_valid = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Pipelined, self-decoding immediate generator; the next generation of the combinational extender.
- Derives immediate format directly from the opcode, with no external imm_src.
- Supports XLEN 32/64 and precomputes pc+imm targets for branch/jump/AUIPC.
- Sits between fetch and execute behind a valid/ready handshake, with a 2-entry skid buffer so backpressure never drops an instruction.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64 only.
- TARGET_EN, 1, 1 = compute out_target; 0 = out_target driven 0.

Ports:
- clk  input  1  clock; one clock domain, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  address of in_instr.
- out_valid  output  1  out_* fields hold a decoded entry.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  sign/zero-extended immediate.
- out_type  output  3  0 R/none, 1 I, 2 S, 3 B, 4 J, 5 U, 7 illegal.
- out_pc  output  XLEN  pc passed through.
- out_target  output  XLEN  out_pc + out_imm, mod 2^XLEN.
- out_illegal  output  1  opcode not recognised.

Behaviour:
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Opcode map (in_instr[6:0]):
  - I: 0000011, 0010011, 1100111, 1110011, 0001111.
  - S: 0100011. B: 1100011. J: 1101111. U: 0110111, 0010111.
  - R: 0110011, imm = 0.
  - XLEN=64 additionally: 0011011 → I, 0111011 → R.
- Immediate formats; sign bit always in[31], extended to XLEN:
  - I: in[31:20].
  - S: {in[31:25], in[11:7]}.
  - B: {in[31], in[7], in[30:25], in[11:8], 0}.
  - J: {in[31], in[19:12], in[20], in[30:21], 0}.
  - U: {in[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
- Shift-immediate encodings are emitted raw as I-type; no shamt masking.
- Any other opcode, or in[1:0] != 2'b11 (RVC disabled): out_type=7, out_illegal=1, out_imm=0, out_target=out_pc. The entry still flows through the pipe and is never dropped.
- Latency: accepted at edge N, visible on out_* after edge N (one cycle).
- Decode is combinational on the input side; results are registered into the main slot or the skid slot.
- Buffer FSM: EMPTY → ONE → TWO.
  - EMPTY: in_ready=1, out_valid=0. Accept → ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept & drain: main reloads, stay ONE.
    - Accept only: write skid, → TWO.
    - Drain only: → EMPTY.
  - TWO: in_ready=0, out_valid=1.
    - Drain: skid moves to main, → ONE.
    - Input ignored while in_ready=0.
- Ordering is strictly FIFO. out_* are stable while out_valid & !out_ready.
- in_ready is a registered function of the next state: 0 only in TWO. No combinational in_ready ← out_ready path.
- Reset (any cycle, including mid-transfer):
  - State → EMPTY, in_ready=1, out_valid=0.
  - out_imm, out_pc, out_target, out_type, out_illegal = 0.
  - Buffered entries are discarded.
- out_target addition wraps silently; no overflow flag.

Optional Feature:
- Macro IMM_RVC_EN.
- Defined: in[1:0] != 2'b11 is decoded as RVC using in[15:0]. Upper half is ignored.
  - C.ADDI/C.LI (q1, f3 000/010) → I: sext{i[12], i[6:2]}.
  - C.J (q1 101) → J: sext{i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 0}.
  - C.BEQZ/C.BNEZ (q1 110/111) → B: sext{i[12], i[6:5], i[2], i[11:10], i[4:3], 0}.
  - C.LW (q0 010) → I, C.SW (q0 110) → S: both zext{i[5], i[12:10], i[6], 00}.
  - Other compressed encodings → illegal.
- Undefined: all compressed words are illegal. No RVC logic is synthesised.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), pc 0x0 → out_type=1, out_imm=0xFFFFFFFF, out_valid exactly one cycle after accept.
- 0x0080006F (jal x0,8), pc 0x1000 → type 4, imm 0x8, target 0x1008. Then 0xFE000EE3 (beq -4), pc 0x100 → type 3, imm 0xFFFFFFFC, target 0xFC.
- 0x123450B7 (lui): XLEN=32 → imm 0x12345000, type 5. Same word with XLEN=64 and 0x800000B7 → imm 0xFFFFFFFF80000000.
- out_ready=0, three back-to-back instructions offered:
  - First two accepted; in_ready=0 from the cycle after the second accept; third is held upstream.
  - Release out_ready → three outputs emerge in order; out_* stable while stalled.
- Opcode 0x7F → out_illegal=1, type 7, imm 0, target=pc. Reset asserted while in TWO → next cycle out_valid=0, in_ready=1, all outputs 0.
- IMM_RVC_EN defined: 0x50FD (c.li x1,-1) → type 1, imm 0xFFFFFFFF. Undefined: same word → out_illegal=1.
